// File: rtl/i_fill_pkg.sv
// Shared definitions for the instruction-cache line-fill block.
package i_fill_pkg;
  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int TAG_W          = 28;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/i_mem_fill_if.sv
// Word-read memory bus between the line-fill engine (master) and memory (slave).
interface i_mem_fill_if;
  import i_fill_pkg::*;

  logic              mem_rd;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_rd, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_rd, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/i_fill_linebuf.sv
// One-line refill buffer: tag, valid bit, line data and the lookup compare.
module i_fill_linebuf
  import i_fill_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inv,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [LINE_W-1:0] rd_data
);
  logic              valid;
  logic [TAG_W-1:0]  tag;
  logic [LINE_W-1:0] data;

  // An invalidate in the same cycle as a write leaves the buffer empty.
  always_ff @(posedge clk) begin
    if (!rst_n)     valid <= 1'b0;
    else if (inv)   valid <= 1'b0;
    else if (wr_en) valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag  <= wr_tag;
      data <= wr_data;
    end
  end

  assign hit     = valid && (tag == lookup_tag);
  assign rd_data = data;
endmodule

// File: rtl/i_mem_fill.sv
// Instruction-cache line-fill engine: fetches four words per miss, serves repeats from a line buffer.
module i_mem_fill
  import i_fill_pkg::*;
#(
  parameter int BUF_EN   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [31:0]       addr,
  input  logic              inv,
  output logic [LINE_W-1:0] line_out,
  output logic              ready,
  output logic              busy,
  output logic              err,
  i_mem_fill_if.master      mem
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [1:0]              state;
  logic [1:0]              cnt;
  logic [WW-1:0]           wcnt;
  logic [31:0]             base;
  logic                    miss;
  logic [3*WORD_W-1:0]     line_asm;
  logic                    lb_hit;
  logic [LINE_W-1:0]       lb_data;
  logic                    hit;

  i_fill_linebuf u_linebuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .inv        (inv),
    .wr_en      ((state == ST_DONE) && miss && (BUF_EN != 0)),
    .wr_tag     (base[31:4]),
    .wr_data    (line_out),
    .lookup_tag (addr[31:4]),
    .hit        (lb_hit),
    .rd_data    (lb_data)
  );

  assign hit          = (BUF_EN != 0) && lb_hit;
  assign ready        = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign mem.mem_rd   = (state == ST_FETCH);
  assign mem.mem_addr = base + {28'd0, cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 2'd0;
      wcnt     <= '0;
      base     <= 32'd0;
      miss     <= 1'b0;
      err      <= 1'b0;
      line_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (hit) begin
              miss     <= 1'b0;
              line_out <= lb_data;
              state    <= ST_DONE;
            end else begin
              base  <= addr & 32'hFFFF_FFF0;
              cnt   <= 2'd0;
              wcnt  <= '0;
              miss  <= 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (mem.mem_ack) begin
            wcnt <= '0;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'(WORDS_PER_LINE - 1)) begin
              line_out <= {mem.mem_rdata, line_asm};
              state    <= ST_DONE;
            end
          // Timeout abandons the fill: no ready pulse and no buffer update.
          end else if (wcnt == WW'(MAX_WAIT - 1)) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Words 0..2 are staged here; word 3 goes straight into line_out with them.
  always_ff @(posedge clk) begin
    if ((state == ST_FETCH) && mem.mem_ack) begin
      case (cnt)
        2'd0:    line_asm[31:0]  <= mem.mem_rdata;
        2'd1:    line_asm[63:32] <= mem.mem_rdata;
        2'd2:    line_asm[95:64] <= mem.mem_rdata;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/i_mem_fill.md
I_MEM_FILL -- requirements
Module: i_mem_fill

Interface
REQ-001 SHALL have parameter BUF_EN, default 1, meaning 1 enables the one-line refill buffer and 0 makes every request go to memory.
REQ-002 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of cycles to wait for mem_ack per word.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset: synchronous, active-low.
REQ-005 req  in  1  line-fill request from the instruction cache; the cache holds it until ready.
REQ-006 addr  in  32  requested address; bits [31:4] select the line.
REQ-007 inv  in  1  invalidates the refill buffer.
REQ-008 line_out  out  128  filled line; word0 is in bits [31:0] and word3 in bits [127:96].
REQ-009 ready  out  1  one-cycle pulse; line_out is valid in that cycle.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 err  out  1  sticky timeout flag.
REQ-012 mem_rd  out  1  memory read strobe, level-held until acknowledged.
REQ-013 mem_addr  out  32  word address to memory.
REQ-014 mem_ack  in  1  read data is valid this cycle; it counts only while mem_rd=1.
REQ-015 mem_rdata  in  32  read data from memory.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and DONE.
REQ-017 In IDLE with req=1, if BUF_EN=1, the buffer is valid and the buffer tag equals addr[31:4], the block SHALL go to DONE with no memory access (buffer hit).
REQ-018 In IDLE with req=1 otherwise, the block SHALL latch base={addr[31:4],4'b0}, clear the word counter cnt and the wait counter, and go to FETCH.
REQ-019 In FETCH, the block SHALL drive mem_rd=1 with mem_addr=base+4*cnt, held stable until the ack cycle.
REQ-020 On mem_ack in FETCH, the block SHALL store mem_rdata into line slot cnt, clear the wait counter and increment cnt; it SHALL go to DONE if cnt was 3.
REQ-021 The block SHALL deassert mem_rd in the cycle after the final ack; between words mem_rd stays 1 and only mem_addr advances.
REQ-022 In FETCH without ack, the wait counter SHALL increment; when it reaches MAX_WAIT the block SHALL set err, drop mem_rd, skip the buffer update and return to IDLE, with no ready pulse.
REQ-023 In DONE, the block SHALL drive ready=1 for exactly one cycle with the assembled or buffered line on line_out, then return to IDLE.
REQ-024 In DONE after a miss, the block SHALL write the line and its tag into the buffer and set the buffer valid.
REQ-025 Latency SHALL be: hit, req sampled at cycle N gives ready at N+1; miss with zero-wait memory gives ready at N+5; each memory wait cycle adds 1.
REQ-026 If req drops mid-fill, the fill SHALL still complete, the buffer SHALL still update and ready SHALL still pulse.
REQ-027 req in DONE or FETCH SHALL NOT start a new fill; the block is single-outstanding.
REQ-028 inv SHALL clear the buffer valid bit in any state; inv in the DONE-update cycle wins, so the buffer ends invalid.
REQ-029 line_out SHALL hold its last value outside DONE.
REQ-030 The block SHALL clear err only by reset; after a timeout, a later req SHALL retry normally.

Reset
REQ-031 While rst_n=0 at a clock edge: state=IDLE, mem_rd=0, mem_addr=0, ready=0, busy=0, err=0, line_out=0, buffer valid=0, cnt=0.
REQ-032 Reset mid-FETCH SHALL abandon the fill immediately; the next cycle shows mem_rd=0 and no ready pulse follows.

Structure
REQ-033 Shared package i_fill_pkg SHALL hold the state encoding, LINE_W=128, WORD_W=32 and WORDS_PER_LINE=4.
REQ-034 The line buffer (tag, valid, 128-bit data, compare) SHALL be a sub-module, i_fill_linebuf; the FSM and counters stay in the top level.

Verification
REQ-035 Miss, zero-wait: req, addr=0x0000_1234, ack every cycle -> mem_addr 0x1230, 0x1234, 0x1238, 0x123C; ready at N+5; line_out = {d3,d2,d1,d0}.
REQ-036 Buffer hit: repeat req addr=0x0000_123C -> no mem_rd; ready at N+1 with the same line.
REQ-037 Invalidate: inv pulse, then req addr=0x0000_1230 -> full memory refetch of 4 words.
REQ-038 Timeout: MAX_WAIT=15, mem_ack held 0 -> mem_rd drops after 15 wait cycles, err=1, no ready; next req with acks -> normal fill, err stays 1.
REQ-039 Wait states: 2-cycle wait per word -> ready at N+13; mem_addr stable during each wait.
REQ-040 Reset mid-fill: rst_n=0 after the second ack -> next cycle mem_rd=0, busy=0, no ready; next req to the same line refetches from memory.
